// File: rtl/arcade_input_ctrl.sv
// Player-input front end: merges PS/2 keys with MiSTer joysticks into active-low controls,
// with pause toggle, coin pulse stretching, per-button autofire and SOCD cleaning.
module arcade_input_ctrl #(
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned NBTN       = 2,
  parameter int unsigned COIN_PULSE = 50000,
  parameter int unsigned AF_HALF    = 200000,
  parameter int unsigned SOCD_CLEAN = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [10:0]                   ps2_key,
  input  logic [16*PLAYERS-1:0]         joy_in,
  input  logic [NBTN-1:0]               af_en,
  input  logic                          soft_rst,
  output logic [(4+NBTN)*PLAYERS-1:0]   ctrl_n,
  output logic [PLAYERS-1:0]            start_n,
  output logic [PLAYERS-1:0]            coin_n,
  output logic                          pause_o
);

  localparam int unsigned CW  = $clog2(COIN_PULSE + 1);
  localparam int unsigned AW  = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
  localparam int unsigned CTW = 4 + NBTN;
  localparam logic [AW-1:0] AF_LAST   = AW'(AF_HALF - 1);
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE);

  // Keyboard tracking
  logic armed_q, tgl_q;
  logic k_up, k_dn, k_lf, k_rt, k_b0a, k_b0b, k_b1, k_b2;
  logic k_st1, k_st2, k_coin, k_pause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      tgl_q   <= 1'b0;
      k_up    <= 1'b0;
      k_dn    <= 1'b0;
      k_lf    <= 1'b0;
      k_rt    <= 1'b0;
      k_b0a   <= 1'b0;
      k_b0b   <= 1'b0;
      k_b1    <= 1'b0;
      k_b2    <= 1'b0;
      k_st1   <= 1'b0;
      k_st2   <= 1'b0;
      k_coin  <= 1'b0;
      k_pause <= 1'b0;
    end else if (!armed_q) begin
      // Adopt whatever toggle level hps_io holds so a stale event is not replayed
      armed_q <= 1'b1;
      tgl_q   <= ps2_key[10];
    end else if (ps2_key[10] != tgl_q) begin
      tgl_q <= ps2_key[10];
      case (ps2_key[7:0])
        8'h75:   k_up    <= ps2_key[9];
        8'h72:   k_dn    <= ps2_key[9];
        8'h6B:   k_lf    <= ps2_key[9];
        8'h74:   k_rt    <= ps2_key[9];
        8'h14:   k_b0a   <= ps2_key[9];
        8'h11:   k_b0b   <= ps2_key[9];
        8'h29:   k_b1    <= ps2_key[9];
        8'h12:   k_b2    <= ps2_key[9];
        8'h05:   k_st1   <= ps2_key[9];
        8'h06:   k_st2   <= ps2_key[9];
        8'h04:   k_coin  <= ps2_key[9];
        8'h0C:   k_pause <= ps2_key[9];
        default: ;
      endcase
    end
  end

  // Merged held state, padded to the maximum player/button counts
  logic [PLAYERS-1:0][3:0] dir_c;
  logic [PLAYERS-1:0][5:0] btn_c;
  logic [3:0]              start_c, coin_c, pause_c;
  logic [5:0]              af_mask;
  logic                    any_af;
  logic [15:0]             jv;

  always_comb begin
    af_mask = 6'(af_en);
    any_af  = 1'b0;
    start_c = '0;
    coin_c  = '0;
    pause_c = '0;
    dir_c   = '0;
    btn_c   = '0;
    jv      = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      jv         = joy_in[16*p +: 16];
      dir_c[p]   = jv[3:0];
      btn_c[p]   = 6'(jv[4 +: NBTN]);
      start_c[p] = jv[4+NBTN];
      coin_c[p]  = jv[5+NBTN];
      pause_c[p] = jv[6+NBTN];
    end
    dir_c[0]   = dir_c[0] | {k_up, k_dn, k_lf, k_rt};
    btn_c[0]   = btn_c[0] | {3'b000, k_b2, k_b1, k_b0a | k_b0b};
    start_c[0] = start_c[0] | k_st1;
    start_c[1] = start_c[1] | k_st2;
    coin_c[0]  = coin_c[0] | k_coin;
    pause_c[0] = pause_c[0] | k_pause;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      if (SOCD_CLEAN != 0 && dir_c[p][3] && dir_c[p][2]) dir_c[p][3:2] = 2'b00;
      if (SOCD_CLEAN != 0 && dir_c[p][1] && dir_c[p][0]) dir_c[p][1:0] = 2'b00;
      any_af = any_af | (|(btn_c[p] & af_mask));
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joy_in, btn_c, start_c, coin_c};

  // Autofire, coin and pause next state
  logic [AW-1:0]              af_cnt_q, af_cnt_d;
  logic                       af_phase_q, af_phase_d;
  logic [PLAYERS-1:0][CW-1:0] coin_cnt_q, coin_cnt_d;
  logic [PLAYERS-1:0]         coin_req_q, coin_busy;
  logic                       pause_req, pause_req_q, pause_d;
  logic [CTW*PLAYERS-1:0]     ctrl_d;

  always_comb begin
    // Idle counter parks with phase high so the first press fires immediately
    if (!any_af) begin
      af_cnt_d   = '0;
      af_phase_d = 1'b1;
    end else if (af_cnt_q == AF_LAST) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end else begin
      af_cnt_d   = af_cnt_q + 1'b1;
      af_phase_d = af_phase_q;
    end

    coin_cnt_d = coin_cnt_q;
    coin_busy  = '0;
    ctrl_d     = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      if (coin_c[p] && !coin_req_q[p] && coin_cnt_q[p] == '0) coin_cnt_d[p] = COIN_LOAD;
      else if (coin_cnt_q[p] != '0)                             coin_cnt_d[p] = coin_cnt_q[p] - 1'b1;
      coin_busy[p] = (coin_cnt_d[p] != '0) | coin_c[p];
      ctrl_d[CTW*p +: CTW] =
        ~{btn_c[p][NBTN-1:0] & (~af_en | {NBTN{af_phase_q}}), dir_c[p]};
    end

    pause_req = |pause_c;
    if (soft_rst)                      pause_d = 1'b0;
    else if (pause_req && !pause_req_q) pause_d = ~pause_o;
    else                               pause_d = pause_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_n      <= '1;
      start_n     <= '1;
      coin_n      <= '1;
      pause_o     <= 1'b0;
      pause_req_q <= 1'b0;
      af_cnt_q    <= '0;
      af_phase_q  <= 1'b1;
      coin_cnt_q  <= '0;
      coin_req_q  <= '0;
    end else begin
      ctrl_n      <= ctrl_d;
      start_n     <= ~start_c[PLAYERS-1:0];
      coin_n      <= ~coin_busy;
      pause_o     <= pause_d;
      pause_req_q <= pause_req;
      af_cnt_q    <= af_cnt_d;
      af_phase_q  <= af_phase_d;
      coin_cnt_q  <= coin_cnt_d;
      coin_req_q  <= coin_c[PLAYERS-1:0];
    end
  end

endmodule
